updown_sweep_ctrl: RTL and testbench

//  Sequencer that drives an integrated up/down count register through programmed

---
 rtl/updown_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - triangular lo->hi->lo sweep sequencer for an up/down count register
//
// Purpose: drives an internal up/down count register through a programmed number
//          of triangular sweeps (lo -> hi -> lo), or forever when cycles == 0.
// Optional feature macro: SWEEP_HOLD_EN (adds the hold input that pauses a sweep).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   start      begin sweeping (IDLE only, ignored while cfg_err is set)
//   stop       abort to IDLE, overrides start and hold
//   hold       (SWEEP_HOLD_EN only) freeze count/state/sweep counter while busy
//   cfg_we     load cfg_lo/cfg_hi (IDLE only)
//   cfg_lo     lower bound
//   cfg_hi     upper bound
//   cycles     number of sweeps, sampled at start; 0 = forever
//   count      current count value
//   up_down    1 = counting up (UP or IDLE), 0 = counting down
//   busy       1 while in UP or DOWN
//   sweep_done one-cycle pulse when the last programmed sweep ends
//   cfg_err    sticky flag for a rejected bound load
module updown_sweep_ctrl #(
  parameter int                 WIDTH      = 8,
  parameter int                 SWEEP_W    = 8,
  parameter logic [WIDTH-1:0]   DEFAULT_LO = 0,
  parameter logic [WIDTH-1:0]   DEFAULT_HI = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
`ifdef SWEEP_HOLD_EN
  input  logic               hold,
`endif
  input  logic               cfg_we,
  input  logic [WIDTH-1:0]   cfg_lo,
  input  logic [WIDTH-1:0]   cfg_hi,
  input  logic [SWEEP_W-1:0] cycles,
  output logic [WIDTH-1:0]   count,
  output logic               up_down,
  output logic               busy,
  output logic               sweep_done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   count_q, count_n;
  logic [WIDTH-1:0]   lo_q, lo_n;
  logic [WIDTH-1:0]   hi_q, hi_n;
  logic [SWEEP_W-1:0] cycles_q, cycles_n;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_n;
  logic               up_down_q, up_down_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               err_q, err_n;
  logic               paused;

`ifdef SWEEP_HOLD_EN
  assign paused = hold;
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    cycles_n = cycles_q;
    sweeps_n = sweeps_q;
    err_n    = err_q;
    done_n   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          if (cfg_lo < cfg_hi) begin
            lo_n  = cfg_lo;
            hi_n  = cfg_hi;
            err_n = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
        // Start uses the bounds and error flag as they stand this cycle.
        if (start && !err_q) begin
          state_n  = UP;
          count_n  = lo_q;
          sweeps_n = '0;
          cycles_n = cycles;
        end
      end
      UP: begin
        if (!paused) begin
          if (count_q < hi_q) begin
            count_n = count_q + 1'b1;
          end else begin
            count_n = count_q - 1'b1;
            state_n = DOWN;
          end
        end
      end
      DOWN: begin
        if (!paused) begin
          if (count_q > lo_q) begin
            count_n = count_q - 1'b1;
          end else if (cycles_q != '0 && sweeps_q + 1'b1 == cycles_q) begin
            state_n  = IDLE;
            count_n  = lo_q;
            sweeps_n = sweeps_q + 1'b1;
            done_n   = 1'b1;
          end else begin
            // lo is not repeated: the next sweep starts at lo+1.
            state_n = UP;
            count_n = lo_q + 1'b1;
            if (sweeps_q != {SWEEP_W{1'b1}}) begin
              sweeps_n = sweeps_q + 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Stop freezes the count where it is; bound loads in IDLE still apply.
    if (stop) begin
      state_n  = IDLE;
      count_n  = count_q;
      sweeps_n = sweeps_q;
      cycles_n = cycles_q;
      done_n   = 1'b0;
    end

    busy_n    = (state_n != IDLE);
    up_down_n = (state_n != DOWN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      lo_q      <= DEFAULT_LO;
      hi_q      <= DEFAULT_HI;
      cycles_q  <= '0;
      sweeps_q  <= '0;
      up_down_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      count_q   <= count_n;
      lo_q      <= lo_n;
      hi_q      <= hi_n;
      cycles_q  <= cycles_n;
      sweeps_q  <= sweeps_n;
      up_down_q <= up_down_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  assign count      = count_q;
  assign up_down    = up_down_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - self-checking bench for updown_sweep_ctrl
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, cfg_we;
  logic [7:0] cfg_lo, cfg_hi, cycles;
  logic [7:0] count;
  logic       up_down, busy, sweep_done, cfg_err;
`ifdef SWEEP_HOLD_EN
  logic       hold = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  updown_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
`ifdef SWEEP_HOLD_EN
    .hold       (hold),
`endif
    .cfg_we     (cfg_we),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .cycles     (cycles),
    .count      (count),
    .up_down    (up_down),
    .busy       (busy),
    .sweep_done (sweep_done),
    .cfg_err    (cfg_err)
  );

  typedef struct {
    logic       start, stop, cfg_we;
    logic [7:0] lo, hi, cyc;
    logic [7:0] e_count;
    logic       e_ud, e_busy, e_done, e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input logic p, input logic w,
                              input logic [7:0] l, input logic [7:0] h, input logic [7:0] c,
                              input logic [7:0] ec, input logic eu, input logic eb,
                              input logic ed, input logic ee);
    vec_t v;
    v.start = s; v.stop = p; v.cfg_we = w; v.lo = l; v.hi = h; v.cyc = c;
    v.e_count = ec; v.e_ud = eu; v.e_busy = eb; v.e_done = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] ec, input logic eu,
                         input logic eb, input logic ed, input logic ee);
    chk({nm, ".count"}, 32'(count), 32'(ec));
    chk({nm, ".up_down"}, 32'(up_down), 32'(eu));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".sweep_done"}, 32'(sweep_done), 32'(ed));
    chk({nm, ".cfg_err"}, 32'(cfg_err), 32'(ee));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; cfg_we = 0; cfg_lo = 0; cfg_hi = 0; cycles = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp;
    logic       dir_up;
    logic       found;

    // lo=2 hi=5, two sweeps
    vq.push_back(mk(0,0,1, 2,5,0, 0,1,0,0,0));
    vq.push_back(mk(1,0,0, 0,0,2, 2,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 3,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 4,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 5,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 4,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 3,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 2,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 3,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 4,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 5,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 4,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 3,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 2,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 2,1,0,1,0));
    vq.push_back(mk(0,0,0, 0,0,0, 2,1,0,0,0));
    // invalid bounds, start ignored, then a valid load clears the error
    vq.push_back(mk(0,0,1, 9,9,0, 2,1,0,0,1));
    vq.push_back(mk(1,0,0, 0,0,1, 2,1,0,0,1));
    vq.push_back(mk(0,0,1, 0,3,0, 2,1,0,0,0));
    vq.push_back(mk(1,0,0, 0,0,1, 0,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 2,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 3,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 2,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,0,1,0));
    // start+stop together stays idle; cfg_we while busy is ignored (hi stays 3)
    vq.push_back(mk(1,1,0, 0,0,1, 0,1,0,0,0));
    vq.push_back(mk(1,0,0, 0,0,1, 0,1,1,0,0));
    vq.push_back(mk(0,0,1, 5,9,0, 1,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 2,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 3,1,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 2,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,0,1,0));
    // lo > hi rejected
    vq.push_back(mk(0,0,1, 7,3,0, 0,1,0,0,1));

    idle_inputs();
    rst = 1'b0;
    #12;
    chk_all("reset", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].start; stop = vq[i].stop; cfg_we = vq[i].cfg_we;
      cfg_lo = vq[i].lo; cfg_hi = vq[i].hi; cycles = vq[i].cyc;
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].e_count, vq[i].e_ud, vq[i].e_busy,
              vq[i].e_done, vq[i].e_err);
    end

    // Forever mode at the top of the range, then stop at 253.
    idle_inputs();
    cfg_we = 1; cfg_lo = 250; cfg_hi = 255;
    tick();
    chk("fwd.cfg_err_cleared", 32'(cfg_err), 32'd0);
    idle_inputs();
    start = 1; cycles = 0;
    tick();
    idle_inputs();
    exp = 250; dir_up = 1'b1;
    chk_all("fwd.start", exp, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      if (dir_up) begin
        if (exp == 8'd255) begin exp = 8'd254; dir_up = 1'b0; end
        else exp = exp + 1'b1;
      end else begin
        if (exp == 8'd250) begin exp = 8'd251; dir_up = 1'b1; end
        else exp = exp - 1'b1;
      end
      tick();
      chk_all($sformatf("fwd.step%0d", k), exp, dir_up, 1'b1, 1'b0, 1'b0);
    end
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (count == 8'd253) found = 1'b1;
      else tick();
    end
    chk("fwd.reached_253", 32'(found), 32'd1);
    stop = 1;
    tick();
    stop = 0;
    chk_all("fwd.stop", 8'd253, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("fwd.after_stop", 8'd253, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-sweep at count=7.
    cfg_we = 1; cfg_lo = 0; cfg_hi = 9;
    tick();
    idle_inputs();
    start = 1; cycles = 0;
    tick();
    idle_inputs();
    for (int k = 0; k < 7; k++) tick();
    chk_all("rst.before", 8'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("rst.async", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    tick();
    chk_all("rst.idle", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef SWEEP_HOLD_EN
    // Default bounds 0..255 after reset; pause at 4 while going up.
    start = 1; cycles = 0;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();
    chk_all("hold.pre", 8'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("hold.frozen%0d", k), 8'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    hold = 1'b0;
    tick();
    chk_all("hold.resume", 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
